// File: rtl/imem_program_loader.sv
// imem_program_loader: framed byte-stream loader for the instruction memory.
// Frame: SYNC, LEN_HI, LEN_LO, LEN payload bytes, CHK (XOR of payload).
// Ports: clk, reset (sync, active-low), in_valid/in_data/in_ready (byte
//   stream), rearm, mem_we/mem_addr/mem_wdata (imem byte write port),
//   cpu_hold (core reset), load_done, load_err, bytes_loaded.
module imem_program_loader #(
    parameter int                    ADDR_WIDTH = 9,
    parameter logic [7:0]            SYNC_BYTE  = 8'hA5,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    input  logic                  rearm,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [7:0]            mem_wdata,
    output logic                  cpu_hold,
    output logic                  load_done,
    output logic                  load_err,
    output logic [15:0]           bytes_loaded
);

    localparam logic [2:0] st_idle   = 3'd0;
    localparam logic [2:0] st_len_hi = 3'd1;
    localparam logic [2:0] st_len_lo = 3'd2;
    localparam logic [2:0] st_data   = 3'd3;
    localparam logic [2:0] st_check  = 3'd4;
    localparam logic [2:0] st_done   = 3'd5;
    localparam logic [2:0] st_error  = 3'd6;

    // Largest image that fits: the whole memory.
    localparam logic [16:0] max_len = 17'd1 << ADDR_WIDTH;

    logic [2:0]            state;
    logic [2:0]            state_n;
    logic [7:0]            len_hi;
    logic [15:0]           len;
    logic [15:0]           len_rx;
    logic [7:0]            chk;
    logic [ADDR_WIDTH-1:0] ptr;
    logic                  take;

    assign take   = in_valid && in_ready;
    assign len_rx = {len_hi, in_data};

    always_comb begin
        state_n = state;
        unique case (state)
            st_idle: begin
                if (take && in_data == SYNC_BYTE) state_n = st_len_hi;
            end
            st_len_hi: begin
                if (take) state_n = st_len_lo;
            end
            st_len_lo: begin
                if (take) begin
                    if ({1'b0, len_rx} > max_len) state_n = st_error;
                    else if (len_rx == 16'd0)     state_n = st_check;
                    else                          state_n = st_data;
                end
            end
            st_data: begin
                // bytes_loaded counts bytes before this one.
                if (take && (bytes_loaded + 16'd1) == len) state_n = st_check;
            end
            st_check: begin
                if (take) state_n = (in_data == chk) ? st_done : st_error;
            end
            st_done, st_error: begin
                if (rearm) state_n = st_idle;
            end
            default: state_n = st_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= st_idle;
            in_ready     <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= BASE_ADDR;
            mem_wdata    <= 8'd0;
            cpu_hold     <= 1'b1;
            load_done    <= 1'b0;
            load_err     <= 1'b0;
            bytes_loaded <= 16'd0;
            len_hi       <= 8'd0;
            len          <= 16'd0;
            chk          <= 8'd0;
            ptr          <= BASE_ADDR;
        end else begin
            state     <= state_n;
            // Status outputs are registered from the next state so they
            // line up with the state register.
            in_ready  <= !(state_n == st_done || state_n == st_error);
            load_done <= (state_n == st_done);
            load_err  <= (state_n == st_error);
            cpu_hold  <= (state_n != st_done);
            mem_we    <= 1'b0;
            if (take) begin
                case (state)
                    st_len_hi: len_hi <= in_data;
                    st_len_lo: begin
                        len          <= len_rx;
                        chk          <= 8'd0;
                        bytes_loaded <= 16'd0;
                        ptr          <= BASE_ADDR;
                    end
                    st_data: begin
                        mem_we       <= 1'b1;
                        mem_addr     <= ptr;
                        mem_wdata    <= in_data;
                        ptr          <= ptr + ADDR_WIDTH'(1);
                        chk          <= chk ^ in_data;
                        bytes_loaded <= bytes_loaded + 16'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_program_loader.sv
// tb_imem_program_loader: directed frames into imem_program_loader,
// write port captured on the falling edge and compared to expected bytes.
module tb_imem_program_loader;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       rearm;
    logic       mem_we;
    logic [8:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       cpu_hold;
    logic       load_done;
    logic       load_err;
    logic [15:0] bytes_loaded;

    imem_program_loader dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .rearm        (rearm),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .cpu_hold     (cpu_hold),
        .load_done    (load_done),
        .load_err     (load_err),
        .bytes_loaded (bytes_loaded)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [8:0] wa[$];
    logic [7:0] wd[$];
    logic [7:0] fr[$];

    // mem_we is high for whole cycles, so one falling-edge sample per pulse.
    always @(negedge clk) begin
        if (mem_we) begin
            wa.push_back(mem_addr);
            wd.push_back(mem_wdata);
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        @(posedge clk);
        #1;
    endtask

    task automatic send_fr();
        foreach (fr[i]) send(fr[i]);
        in_valid = 1'b0;
    endtask

    task automatic clr_wr();
        wa.delete();
        wd.delete();
    endtask

    task automatic settle();
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic do_rearm();
        rearm = 1'b1;
        @(posedge clk);
        #1;
        rearm = 1'b0;
    endtask

    logic [7:0] pl[16];
    logic [7:0] x;
    logic       ok;

    initial begin
        reset    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        rearm    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_cpu_hold", cpu_hold, 1);
        check("rst_done", load_done, 0);
        check("rst_err", load_err, 0);
        check("rst_bytes", bytes_loaded, 0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("idle_in_ready", in_ready, 1);

        // Good frame: DE^AD^BE^EF = 22.
        clr_wr();
        fr = '{8'hA5, 8'h00, 8'h04, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h22};
        send_fr();
        settle();
        check("t1_nwr", wa.size(), 4);
        if (wa.size() == 4) begin
            check("t1_a0", {wa[0], wd[0]}, {9'd0, 8'hDE});
            check("t1_a1", {wa[1], wd[1]}, {9'd1, 8'hAD});
            check("t1_a2", {wa[2], wd[2]}, {9'd2, 8'hBE});
            check("t1_a3", {wa[3], wd[3]}, {9'd3, 8'hEF});
        end
        check("t1_bytes", bytes_loaded, 4);
        check("t1_done", load_done, 1);
        check("t1_err", load_err, 0);
        check("t1_hold", cpu_hold, 0);
        check("t1_ready", in_ready, 0);
        do_rearm();
        check("t1_rearm_done", load_done, 0);
        check("t1_rearm_hold", cpu_hold, 1);
        check("t1_rearm_ready", in_ready, 1);
        check("t1_rearm_bytes", bytes_loaded, 4);

        // Bad checksum.
        clr_wr();
        fr = '{8'hA5, 8'h00, 8'h04, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01};
        send_fr();
        settle();
        check("t2_nwr", wa.size(), 4);
        check("t2_err", load_err, 1);
        check("t2_done", load_done, 0);
        check("t2_hold", cpu_hold, 1);
        check("t2_ready", in_ready, 0);
        do_rearm();
        check("t2_rearm_err", load_err, 0);
        check("t2_rearm_ready", in_ready, 1);

        // Garbage then zero-length frame.
        clr_wr();
        fr = '{8'h00, 8'hFF, 8'h13, 8'hA5, 8'h00, 8'h00, 8'h00};
        send_fr();
        settle();
        check("t3_nwr", wa.size(), 0);
        check("t3_done", load_done, 1);
        check("t3_bytes", bytes_loaded, 0);
        do_rearm();

        // Oversize length.
        clr_wr();
        fr = '{8'hA5, 8'h02, 8'h01};
        send_fr();
        check("t4_err", load_err, 1);
        check("t4_ready", in_ready, 0);
        settle();
        check("t4_nwr", wa.size(), 0);
        do_rearm();

        // 16-byte payload with in_valid gaps.
        clr_wr();
        x = 8'h00;
        for (int i = 0; i < 16; i++) begin
            pl[i] = 8'(i * 37 + 5);
            x = x ^ pl[i];
        end
        send(8'hA5);
        send(8'h00);
        send(8'h10);
        for (int i = 0; i < 16; i++) begin
            send(pl[i]);
            in_valid = 1'b0;
            repeat (i % 3) @(posedge clk);
            #1;
        end
        send(x);
        settle();
        check("t5_nwr", wa.size(), 16);
        if (wa.size() == 16) begin
            for (int i = 0; i < 16; i++)
                check($sformatf("t5_w%0d", i), {wa[i], wd[i]},
                      {9'(i), pl[i]});
        end
        check("t5_done", load_done, 1);
        check("t5_bytes", bytes_loaded, 16);
        do_rearm();

        // Full-memory image: every address once, payload i[7:0].
        clr_wr();
        send(8'hA5);
        send(8'h02);
        send(8'h00);
        for (int i = 0; i < 512; i++) send(8'(i));
        send(8'h00);
        settle();
        check("t6_nwr", wa.size(), 512);
        ok = (wa.size() == 512);
        if (ok) begin
            for (int i = 0; i < 512; i++)
                if (wa[i] != 9'(i) || wd[i] != 8'(i)) ok = 1'b0;
        end
        check("t6_all", ok, 1);
        check("t6_done", load_done, 1);
        check("t6_bytes", bytes_loaded, 512);
        do_rearm();

        // Reset after payload byte 2 of 4.
        clr_wr();
        fr = '{8'hA5, 8'h00, 8'h04, 8'h11, 8'h22};
        send_fr();
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("t7_we", mem_we, 0);
        check("t7_hold", cpu_hold, 1);
        check("t7_ready", in_ready, 0);
        check("t7_bytes", bytes_loaded, 0);
        check("t7_addr", mem_addr, 0);
        reset = 1'b1;
        settle();
        check("t7_nwr", wa.size(), 2);
        clr_wr();
        fr = '{8'hA5, 8'h00, 8'h03, 8'h01, 8'h02, 8'h04, 8'h07};
        send_fr();
        settle();
        check("t7b_nwr", wa.size(), 3);
        if (wa.size() == 3) begin
            check("t7b_w0", {wa[0], wd[0]}, {9'd0, 8'h01});
            check("t7b_w2", {wa[2], wd[2]}, {9'd2, 8'h04});
        end
        check("t7b_done", load_done, 1);
        check("t7b_hold", cpu_hold, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
